// File: rtl/demux2_buf_pkg.sv
// Shared constants for the two-channel buffered demultiplexer.
package demux2_buf_pkg;

    // Default data path width in bits.
    localparam int WIDTH_DEF = 16;

    // Entries held by each output channel buffer.
    localparam int DEPTH = 2;

    // Width of the per-channel occupancy count (holds 0..DEPTH).
    localparam int CNT_W = 2;

    // Occupancy value at which a channel refuses further pushes.
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

endpackage : demux2_buf_pkg

// File: rtl/demux2_buf_if.sv
// Handshake bundle between the producer, the demux and the two consumers.
// Valid/ready rule on every port: a word moves at a rising edge only when
// valid and ready are both 1; the sender holds its word while valid=1 and
// ready=0, and ready never depends on valid of the same port.
interface demux2_buf_if #(
    parameter int WIDTH = demux2_buf_pkg::WIDTH_DEF
);

    // Producer side.
    logic                                in_valid;
    logic                                in_ready;
    logic [WIDTH-1:0]                    in_data;
    logic                                in_sel;

    // Channel 0 consumer side.
    logic                                out0_valid;
    logic                                out0_ready;
    logic [WIDTH-1:0]                    out0_data;

    // Channel 1 consumer side.
    logic                                out1_valid;
    logic                                out1_ready;
    logic [WIDTH-1:0]                    out1_data;

    // Occupancy of each channel.
    logic [demux2_buf_pkg::CNT_W-1:0]    count0;
    logic [demux2_buf_pkg::CNT_W-1:0]    count1;

    // Environment view: drives the producer and consumer-ready signals.
    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
               count0, count1
    );

    // Demux view.
    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data,
               count0, count1
    );

endinterface : demux2_buf_if

// File: rtl/demux2_buf_fifo2.sv
// Two-entry FIFO with valid/ready on both sides and an occupancy output.
// Push is refused while full even if a pop happens the same cycle, so the
// push-side ready depends only on the stored count.
module fifo2
    import demux2_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_pop_valid,
    input  logic             i_pop_ready,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_push_ready = (r_count != FULL_COUNT);
    assign o_pop_valid  = (r_count != '0);
    assign o_pop_data   = r_mem[r_rd_ptr];
    assign o_count      = r_count;

    assign w_push = i_push_valid & o_push_ready;
    assign w_pop  = o_pop_valid & i_pop_ready;

    // Storage write at the tail; reset clears every entry so the head reads zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // One-bit pointers wrap naturally from 1 back to 0; count tracks push minus pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule : fifo2

// File: rtl/demux2_buf.sv
// Routes each accepted input word into one of two 2-entry channel buffers.
// This level holds only the steering and the in_ready selection; all
// storage lives in the two fifo2 instances.
module demux2_buf
    import demux2_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    demux2_buf_if.slave    bus
);

    logic w_push0;
    logic w_push1;
    logic w_ready0;
    logic w_ready1;

    // Only the selected channel sees the offer; in_ready follows in_sel alone.
    assign w_push0     = bus.in_valid & ~bus.in_sel;
    assign w_push1     = bus.in_valid &  bus.in_sel;
    assign bus.in_ready = bus.in_sel ? w_ready1 : w_ready0;

    fifo2 #(.WIDTH(WIDTH)) u_ch0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_push_valid (w_push0),
        .o_push_ready (w_ready0),
        .i_push_data  (bus.in_data),
        .o_pop_valid  (bus.out0_valid),
        .i_pop_ready  (bus.out0_ready),
        .o_pop_data   (bus.out0_data),
        .o_count      (bus.count0)
    );

    fifo2 #(.WIDTH(WIDTH)) u_ch1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_push_valid (w_push1),
        .o_push_ready (w_ready1),
        .i_push_data  (bus.in_data),
        .o_pop_valid  (bus.out1_valid),
        .i_pop_ready  (bus.out1_ready),
        .o_pop_data   (bus.out1_data),
        .o_count      (bus.count1)
    );

endmodule : demux2_buf

// File: tb/tb_demux2_buf.sv
// Testbench for demux2_buf: directed scenarios followed by random traffic,
// checked against per-channel word queues at every falling edge.
module tb_demux2_buf;

    localparam int W = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp0_q [$];
    logic [W-1:0] exp1_q [$];

    demux2_buf_if #(.WIDTH(W)) bus ();

    demux2_buf #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of stimulus just after a rising edge, then waits for the next.
    task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    // At each falling edge: compare DUT outputs with the queue model, then
    // apply the handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        int  n0;
        int  n1;
        int  nsel;
        logic accept;
        if (!reset_n) begin
            exp0_q.delete();
            exp1_q.delete();
            check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
            check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
            check("rst_count0",     32'(bus.count0),     32'd0);
            check("rst_count1",     32'(bus.count1),     32'd0);
            check("rst_in_ready",   32'(bus.in_ready),   32'd1);
        end else begin
            n0   = exp0_q.size();
            n1   = exp1_q.size();
            nsel = bus.in_sel ? n1 : n0;
            check("in_ready",   32'(bus.in_ready),   32'(nsel < 2));
            check("out0_valid", 32'(bus.out0_valid), 32'(n0 > 0));
            check("out1_valid", 32'(bus.out1_valid), 32'(n1 > 0));
            check("count0",     32'(bus.count0),     32'(n0));
            check("count1",     32'(bus.count1),     32'(n1));
            if (n0 > 0) check("out0_data", 32'(bus.out0_data), 32'(exp0_q[0]));
            if (n1 > 0) check("out1_data", 32'(bus.out1_data), 32'(exp1_q[0]));
            accept = bus.in_valid && (nsel < 2);
            if (n0 > 0 && bus.out0_ready) void'(exp0_q.pop_front());
            if (n1 > 0 && bus.out1_ready) void'(exp1_q.pop_front());
            if (accept) begin
                if (bus.in_sel) exp1_q.push_back(bus.in_data);
                else            exp0_q.push_back(bus.in_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] held;
        logic [1:0]   held_cnt;

        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;

        // Power-on reset, released just after a rising edge.
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Routing: one word to each channel, consumers ready.
        drive(1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Full channel 0: third push refused while selected, other side open.
        drive(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
        check("full_count0", 32'(bus.count0), 32'd2);
        check("full_in_ready_sel0", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 1'b0, 16'h0003, 1'b1, 1'b0);
        bus.in_sel = 1'b1;
        #1;
        check("full_in_ready_sel1", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Order and pointer wrap on channel 1 with push and pop each cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, W'(16'h0010 + i), 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Simultaneous push and pop on channel 0 at count 1.
        drive(1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'hBBBB, 1'b1, 1'b0);
        check("simul_count0", 32'(bus.count0), 32'd1);
        check("simul_out0_data", 32'(bus.out0_data), 32'hBBBB);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure on channel 1 for five cycles.
        drive(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'hC3C3, 1'b0, 1'b0);
        held     = 16'h5A5A;
        held_cnt = 2'd2;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0);
            check("bp_out1_data", 32'(bus.out1_data), 32'(held));
            check("bp_count1",    32'(bus.count1),    32'(held_cnt));
        end

        // Fill channel 0 too, then assert reset between edges.
        drive(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out0_valid", 32'(bus.out0_valid), 32'd0);
        check("arst_out1_valid", 32'(bus.out1_valid), 32'd0);
        check("arst_count0",     32'(bus.count0),     32'd0);
        check("arst_count1",     32'(bus.count1),     32'd0);
        check("arst_out0_data",  32'(bus.out0_data),  32'h0000);
        check("arst_out1_data",  32'(bus.out1_data),  32'h0000);
        bus.in_sel = 1'b0;
        #1;
        check("arst_in_ready0", 32'(bus.in_ready), 32'd1);
        bus.in_sel = 1'b1;
        #1;
        check("arst_in_ready1", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First push right after release is taken at the next edge.
        drive(1'b1, 1'b0, 16'h7E57, 1'b0, 1'b0);
        check("post_rst_count0", 32'(bus.count0), 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6));
        end

        // Drain.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_demux2_buf

// File: doc/demux2_buf.md
DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 Parameter: WIDTH, default 16, data path width in bits.
REQ-002 Parameter: DEPTH, fixed at 2, entries per output channel buffer.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers in_data this cycle.
REQ-006 in_ready  output  1  selected channel can accept this cycle.
REQ-007 in_data  input  WIDTH  word to be routed.
REQ-008 in_sel  input  1  destination: 0 to channel 0, 1 to channel 1.
REQ-009 out0_valid  output  1  channel 0 head entry valid.
REQ-010 out0_ready  input  1  channel 0 consumer accepts head.
REQ-011 out0_data  output  WIDTH  channel 0 head word.
REQ-012 out1_valid / out1_ready / out1_data  as REQ-009..011 for channel 1.
REQ-013 count0, count1  output  2  occupancy of each channel, 0..2.

Function
REQ-014 Input transfer occurs when in_valid and in_ready are both 1 at a rising edge; the word is written to the tail of the channel named by in_sel.
REQ-015 in_ready SHALL be 1 iff the channel selected by in_sel has count < 2; it depends combinationally on in_sel only, never on in_valid or the out*_ready inputs.
REQ-016 Output transfer on channel k occurs when outk_valid and outk_ready are both 1 at a rising edge; the head entry is removed.
REQ-017 outk_valid SHALL be 1 iff countk > 0; outk_data SHALL equal the oldest unremoved word of channel k and be held stable while outk_valid=1 and outk_ready=0.
REQ-018 Latency: a word accepted at edge N appears at outk_data with outk_valid=1 after edge N when the channel was empty; no combinational bypass from in_data to outk_data.
REQ-019 Order: words within a channel SHALL leave in acceptance order; no ordering relation between channels.
REQ-020 Simultaneous push and pop on the same channel with count 1 SHALL leave count 1 and the new word at head after the edge.
REQ-021 Full channel (count 2): in_ready=0 when selected, even if outk_ready=1 that cycle (no push-through on full); the other channel is unaffected.
REQ-022 Empty channel: outk_ready is ignored; count stays 0, no underflow.
REQ-023 Both channels may pop in the same cycle as a push to either channel.
REQ-024 Internal read/write pointers are 1 bit each and wrap 1 to 0; count updates as count + push - pop, saturating never required (guaranteed by REQ-015/022).
REQ-025 in_data and in_sel are sampled only on an accepted transfer; their values at other times SHALL not affect state.

Reset
REQ-026 reset_n=0 SHALL immediately, without a clock edge, clear both counts and pointers, drive out0_valid=out1_valid=0, count0=count1=0.
REQ-027 outk_data after reset SHALL be all zeros (storage cleared).
REQ-028 Reset asserted mid-transfer SHALL discard all buffered words; in_ready becomes 1 for both selections while reset_n=0 and after release.
REQ-029 First transfer is accepted at the first rising edge after reset_n deasserts.

Structure
REQ-030 Shared package holds WIDTH default (16), DEPTH (2) and the count width constant (2).
REQ-031 One sub-module, fifo2 (2-entry FIFO with valid/ready on both sides and count output), SHALL be instantiated twice; demux2_buf holds only the routing and in_ready logic.

Verification
REQ-032 Reset: reset_n=0 asynchronously mid-cycle with both channels full -> out0_valid=out1_valid=0, count0=count1=0 immediately, out data 16'h0000.
REQ-033 Routing: push 16'h1234 with in_sel=0 then 16'hABCD with in_sel=1, outputs ready -> out0_data=16'h1234 one cycle after first push, out1_data=16'hABCD one cycle after second; other channel valid stays 0.
REQ-034 Full: three pushes 16'h0001,16'h0002,16'h0003 to channel 0 with out0_ready=0 -> first two accepted, count0=2, in_ready=0 for third while in_sel=0; set in_sel=1 -> in_ready=1.
REQ-035 Order/wrap: alternate push/pop on channel 1 for 8 words 16'h0010..16'h0017 -> out1 emits 16'h0010..16'h0017 in order, count1 never exceeds 2.
REQ-036 Simultaneous: channel 0 count 1 holding 16'hAAAA, push 16'hBBBB with out0_ready=1 same edge -> count0 stays 1, out0_data=16'hBBBB next cycle.
REQ-037 Backpressure stability: out1_valid=1, out1_ready=0 for 5 cycles -> out1_data unchanged, count1 unchanged.
